// File: rtl/multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer
//
// Sequences one multiply or divide on an external multi-cycle mult/div unit and
// owns the architectural HI/LO registers.
//
// An accepted request drives md_ctrl (01 = mult, 10 = div) for N consecutive
// cycles. md_ctrl then drops to 00 for one CAPTURE cycle. On the following edge
// md_hi/md_lo are written into HI/LO and done pulses for one cycle.
// A divide that reports md_divzero leaves HI/LO untouched and raises
// div_zero_exc together with done.
// mthi/mtlo writes (mt_hi/mt_lo) are accepted only while idle, and a
// simultaneous start takes priority over them.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   start, op      request (op: 0 = mult, 1 = div), sampled in IDLE
//   rs_val, rt_val operands; rs_val is also the mthi/mtlo source
//   mt_hi, mt_lo   write rs_val to HI / LO while idle
//   md_a, md_b     registered operands to the mult/div unit
//   md_ctrl        00 idle, 01 mult, 10 div
//   md_hi, md_lo   results from the mult/div unit
//   md_divzero     divide-by-zero flag from the mult/div unit
//   busy           operation in flight
//   done           one-cycle completion pulse
//   div_zero_exc   one-cycle divide-by-zero pulse, coincident with done
//   hi_out, lo_out architectural HI / LO
//
// Build option
//   MULTDIV_SEQUENCER_DIVZERO_EARLY_EN : when defined, a divide that sees
//   md_divzero while running is cut short and moves straight to CAPTURE.
// -----------------------------------------------------------------------------
module multdiv_sequencer #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mt_hi,
  input  logic        mt_lo,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [1:0]  md_ctrl,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        md_divzero,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    CAPTURE = 2'b10
  } state_t;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_MULT = 2'b01;
  localparam logic [1:0] CTRL_DIV  = 2'b10;

  // The counter holds the number of RUN cycles already completed, so the last
  // RUN cycle is the one in which it equals N-1.
  localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES - 1);
  localparam logic [5:0] CNT_MAX   = 6'h3f;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_q, op_d;           // 1 = current operation is a divide
  logic        early_q, early_d;     // divide was cut short by md_divzero
  logic [31:0] md_a_q, md_a_d;
  logic [31:0] md_b_q, md_b_d;
  logic [1:0]  md_ctrl_q, md_ctrl_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        early_abort;
  logic [5:0]  cnt_last;

`ifdef MULTDIV_SEQUENCER_DIVZERO_EARLY_EN
  assign early_abort = op_q & md_divzero;
`else
  assign early_abort = 1'b0;
`endif

  assign cnt_last = op_q ? DIV_LAST : MULT_LAST;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    early_d   = early_q;
    md_a_d    = md_a_q;
    md_b_d    = md_b_q;
    md_ctrl_d = md_ctrl_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    exc_d     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // start has priority: any mt write in the same cycle is dropped
          md_a_d    = rs_val;
          md_b_d    = rt_val;
          md_ctrl_d = op ? CTRL_DIV : CTRL_MULT;
          op_d      = op;
          early_d   = 1'b0;
          cnt_d     = 6'd0;
          busy_d    = 1'b1;
          state_d   = RUN;
        end else begin
          if (mt_hi) hi_d = rs_val;
          if (mt_lo) lo_d = rs_val;
        end
      end

      RUN: begin
        if (early_abort) begin
          md_ctrl_d = CTRL_IDLE;
          early_d   = 1'b1;
          state_d   = CAPTURE;
        end else if (cnt_q == cnt_last) begin
          md_ctrl_d = CTRL_IDLE;
          state_d   = CAPTURE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      CAPTURE: begin
        // md_ctrl is already 00 here; results are taken on this edge
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (op_q && (md_divzero || early_q)) begin
          exc_d = 1'b1;
        end else begin
          hi_d = md_hi;
          lo_d = md_lo;
        end
      end

      default: begin
        state_d   = IDLE;
        md_ctrl_d = CTRL_IDLE;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 1'b0;
      early_q   <= 1'b0;
      md_a_q    <= 32'd0;
      md_b_q    <= 32'd0;
      md_ctrl_q <= CTRL_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      exc_q     <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      early_q   <= early_d;
      md_a_q    <= md_a_d;
      md_b_q    <= md_b_d;
      md_ctrl_q <= md_ctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      exc_q     <= exc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign md_a         = md_a_q;
  assign md_b         = md_b_q;
  assign md_ctrl      = md_ctrl_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign div_zero_exc = exc_q;
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for multdiv_sequencer.
//
// Cycle numbering: cycle k is the k-th clock period after the edge that accepts
// start. The bench samples each cycle 1 time unit after its opening edge.
// Under that numbering, md_ctrl is nonzero in cycles 1..N, CAPTURE is cycle
// N+1, and done/div_zero_exc are high in cycle N+2.
//
// The mult/div unit is modelled as a combinational responder. Its result and
// div-by-zero flag stay valid after md_ctrl returns to 00.
// -----------------------------------------------------------------------------
module tb_multdiv_sequencer;

  localparam int MULT_N = 32;
  localparam int DIV_N  = 33;
`ifdef MULTDIV_SEQUENCER_DIVZERO_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start, op, mt_hi, mt_lo;
  logic [31:0] rs_val, rt_val;
  logic [31:0] md_a, md_b, md_hi, md_lo, hi_out, lo_out;
  logic [1:0]  md_ctrl;
  logic        md_divzero, busy, done, div_zero_exc;

  int checks = 0;
  int errors = 0;

  // architectural HI/LO as the bench expects them
  logic [31:0] model_hi, model_lo;

  always #5 clk = ~clk;

  multdiv_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mt_hi(mt_hi), .mt_lo(mt_lo),
    .md_a(md_a), .md_b(md_b), .md_ctrl(md_ctrl),
    .md_hi(md_hi), .md_lo(md_lo), .md_divzero(md_divzero),
    .busy(busy), .done(done), .div_zero_exc(div_zero_exc),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  // ---------------- mult/div unit responder ----------------
  logic last_div = 1'b0;
  logic resp_div;
  logic [63:0] resp_prod;
  always @(posedge clk) if (md_ctrl != 2'b00) last_div <= (md_ctrl == 2'b10);
  assign resp_div = (md_ctrl == 2'b10) || ((md_ctrl == 2'b00) && last_div);
  always_comb begin
    resp_prod  = {32'd0, md_a} * {32'd0, md_b};
    md_divzero = 1'b0;
    md_hi      = resp_prod[63:32];
    md_lo      = resp_prod[31:0];
    if (resp_div) begin
      md_divzero = (md_b == 32'd0);
      md_hi      = (md_b == 32'd0) ? 32'd0 : md_a % md_b;
      md_lo      = (md_b == 32'd0) ? 32'd0 : md_a / md_b;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mthi/mtlo while idle
  task automatic mt_write(input logic hi_en, input logic lo_en, input logic [31:0] val);
    @(negedge clk);
    mt_hi = hi_en; mt_lo = lo_en; rs_val = val;
    @(posedge clk); #1;
    mt_hi = 1'b0; mt_lo = 1'b0; rs_val = $urandom;
    if (hi_en) model_hi = val;
    if (lo_en) model_lo = val;
    check("mt_hi_out", {32'd0, hi_out}, {32'd0, model_hi});
    check("mt_lo_out", {32'd0, lo_out}, {32'd0, model_lo});
    $display("mt   hi_en=%0d lo_en=%0d val=%h -> hi=%h lo=%h", hi_en, lo_en, val, hi_out, lo_out);
  endtask

  // One operation. ign_cyc > 0 raises start/mt_hi/mt_lo (with fresh rs_val)
  // during that busy cycle; with_mt asserts mt_lo together with start.
  task automatic run_op(input logic op_i, input logic [31:0] a, input logic [31:0] b,
                        input int ign_cyc, input logic with_mt);
    int n, exp_ctrl, exp_done, ctrl_cycles, first_nz, last_nz, done_cyc, c;
    logic exc_seen, bad_code, ops_moved, stray_exc, zero_div;
    logic [1:0] code;
    logic [63:0] prod;
    logic [31:0] exp_hi, exp_lo;

    n        = op_i ? DIV_N : MULT_N;
    code     = op_i ? 2'b10 : 2'b01;
    zero_div = op_i && (b == 32'd0);
    exp_ctrl = (zero_div && EARLY) ? 1 : n;
    exp_done = exp_ctrl + 2;
    prod     = {32'd0, a} * {32'd0, b};
    if (zero_div) begin
      exp_hi = model_hi; exp_lo = model_lo;
    end else if (op_i) begin
      exp_hi = a % b; exp_lo = a / b;
    end else begin
      exp_hi = prod[63:32]; exp_lo = prod[31:0];
    end

    @(negedge clk);
    start = 1'b1; op = op_i; rs_val = a; rt_val = b; mt_lo = with_mt;
    @(posedge clk); #1;
    start = 1'b0; mt_lo = 1'b0; rs_val = $urandom; rt_val = $urandom;
    check("accept_busy", {63'd0, busy}, 64'd1);
    check("accept_lo_no_mt", {32'd0, lo_out}, {32'd0, model_lo});

    ctrl_cycles = 0; first_nz = 0; last_nz = 0; done_cyc = 0; c = 1;
    exc_seen = 1'b0; bad_code = 1'b0; ops_moved = 1'b0; stray_exc = 1'b0;
    while (done_cyc == 0 && c <= n + 8) begin
      if (md_ctrl != 2'b00) begin
        ctrl_cycles++;
        if (first_nz == 0) first_nz = c;
        last_nz = c;
        if (md_ctrl != code) bad_code = 1'b1;
      end
      if (md_a !== a || md_b !== b) ops_moved = 1'b1;
      if (div_zero_exc && !done) stray_exc = 1'b1;
      if (done) begin
        done_cyc = c;
        exc_seen = div_zero_exc;
        check("busy_at_done", {63'd0, busy}, 64'd0);
        check("ctrl_at_done", {62'd0, md_ctrl}, 64'd0);
      end
      if (c == ign_cyc) begin
        start = 1'b1; op = ~op_i; mt_hi = 1'b1; mt_lo = 1'b1; rs_val = $urandom;
      end
      if (ign_cyc > 0 && c == ign_cyc + 1) begin
        start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
        check("mt_ignored_busy", {hi_out, lo_out}, {model_hi, model_lo});
      end
      if (done_cyc == 0) begin
        @(posedge clk); #1;
        c++;
      end
    end

    check("done_cycle", 64'(done_cyc), 64'(exp_done));
    check("ctrl_cycles", 64'(ctrl_cycles), 64'(exp_ctrl));
    check("ctrl_first", 64'(first_nz), 64'd1);
    check("ctrl_last", 64'(last_nz), 64'(exp_ctrl));
    check("ctrl_code", {63'd0, bad_code}, 64'd0);
    check("operands_stable", {63'd0, ops_moved}, 64'd0);
    check("exc_with_done", {62'd0, stray_exc, exc_seen}, {63'd0, zero_div});
    check("hi_out", {32'd0, hi_out}, {32'd0, exp_hi});
    check("lo_out", {32'd0, lo_out}, {32'd0, exp_lo});
    model_hi = exp_hi; model_lo = exp_lo;
    $display("op=%0d a=%h b=%h done@%0d ctrl=%0d exc=%0d hi=%h lo=%h",
             op_i, a, b, done_cyc, ctrl_cycles, exc_seen, hi_out, lo_out);

    // one cycle later: pulses gone, nothing queued
    @(posedge clk); #1;
    check("post_pulses", {62'd0, done, div_zero_exc}, 64'd0);
    check("post_idle", {61'd0, busy, md_ctrl}, 64'd0);
  endtask

  initial begin
    int quiet_done;
    logic r_op;
    logic [31:0] r_a, r_b;

    start = 0; op = 0; mt_hi = 0; mt_lo = 0; rs_val = 0; rt_val = 0;
    model_hi = 0; model_lo = 0;

    // reset takes effect before any clock edge
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset_outs", {hi_out, lo_out}, 64'd0);
    check("reset_ctrl", {29'd0, md_ctrl, busy, done, div_zero_exc}, 64'd0);
    check("reset_ops", {md_a, md_b}, 64'd0);
    $display("reset asserted: ctrl=%0d busy=%0d hi=%h lo=%h", md_ctrl, busy, hi_out, lo_out);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    // multiply with an ignored start pulse at cycle 10, then back-to-back div
    run_op(1'b0, 32'h0001_0000, 32'h0003_0000, 10, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 5, 1'b0);

    // divide by zero with HI/LO preloaded
    mt_write(1'b1, 1'b0, 32'h1111_1111);
    mt_write(1'b0, 1'b1, 32'h2222_2222);
    run_op(1'b1, 32'd5, 32'd0, 0, 1'b0);

    // mthi while idle, then mtlo colliding with start
    mt_write(1'b1, 1'b0, 32'hDEAD_BEEF);
    run_op(1'b0, 32'd5, 32'd6, 0, 1'b1);

    // asynchronous reset in cycle 12 of a divide
    @(negedge clk);
    start = 1'b1; op = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midreset_ctrl_busy", {61'd0, md_ctrl, busy}, 64'd0);
    check("midreset_hi_lo", {hi_out, lo_out}, 64'd0);
    $display("mid-op reset: ctrl=%0d busy=%0d hi=%h", md_ctrl, busy, hi_out);
    model_hi = 0; model_lo = 0;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    quiet_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || div_zero_exc) quiet_done++;
    end
    check("no_done_after_abort", 64'(quiet_done), 64'd0);
    run_op(1'b0, 32'd3, 32'd4, 0, 1'b0);

    // both mt writes in one cycle
    mt_write(1'b1, 1'b1, $urandom);

    // random operations against the arithmetic model
    for (int i = 0; i < 6; i++) begin
      r_op = 1'($urandom_range(0, 1));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) mt_write(1'b1, 1'b1, $urandom);
      run_op(r_op, r_a, r_b, (r_op && r_b == 0) ? 0 : 4 + i, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- MULT_CYCLES, default 32, number of consecutive cycles md_ctrl is held at 01 for a multiply.
- DIV_CYCLES, default 33, number of consecutive cycles md_ctrl is held at 10 for a divide.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  operation request from the control unit.
- op  in  1  0=mult, 1=div; sampled with start.
- rs_val  in  32  operand A; also the mthi/mtlo source.
- rt_val  in  32  operand B.
- mt_hi  in  1  write rs_val to HI.
- mt_lo  in  1  write rs_val to LO.
- md_a  out  32  registered operand A to the mult/div unit.
- md_b  out  32  registered operand B to the mult/div unit.
- md_ctrl  out  2  00 idle, 01 mult, 10 div.
- md_hi  in  32  Hi result from the mult/div unit.
- md_lo  in  32  Lo result from the mult/div unit.
- md_divzero  in  1  divide-by-zero flag from the mult/div unit.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- div_zero_exc  out  1  one-cycle exception pulse, coincident with done.
- hi_out  out  32  architectural HI register.
- lo_out  out  32  architectural LO register.

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, RUN and CAPTURE, with all outputs registered.
REQ-004 In IDLE, start=1 at a rising edge SHALL latch rs_val into md_a and rt_val into md_b, set md_ctrl to 01 (op=0) or 10 (op=1), clear the cycle counter, set busy=1, and go to RUN.
REQ-005 md_a and md_b SHALL stay constant from acceptance until the block returns to IDLE.
REQ-006 md_ctrl SHALL be nonzero for exactly N consecutive cycles, where N is MULT_CYCLES or DIV_CYCLES; on the edge that ends cycle N it SHALL go to 00 and the FSM SHALL enter CAPTURE.
REQ-007 In CAPTURE, the next edge SHALL load md_hi into hi_out and md_lo into lo_out, pulse done for one cycle, clear busy, and return to IDLE.
REQ-008 Latency from the start-accept edge to the edge raising done SHALL be N+2 cycles: 34 for mult, 35 for div.
REQ-009 start while busy=1 SHALL be ignored; no request is queued.
REQ-010 md_ctrl SHALL be 00 for at least two cycles between consecutive operations, so the mult/div unit sees a 0-to-nonzero edge and reinitialises.
REQ-011 If md_divzero=1 in CAPTURE for a div, the block SHALL leave hi_out and lo_out unchanged and pulse div_zero_exc together with done.
REQ-012 md_divzero SHALL be ignored for mult.
REQ-013 In IDLE with start=0, mt_hi=1 SHALL load rs_val into hi_out and mt_lo=1 SHALL load rs_val into lo_out on the next edge; both may act in the same cycle.
REQ-014 If start and mt_hi/mt_lo are asserted in the same cycle, start SHALL win and the mt write SHALL be dropped.
REQ-015 mt_hi and mt_lo SHALL be ignored while busy=1.
REQ-016 The counter SHALL be 6 bits wide and SHALL saturate rather than wrap.

Reset
REQ-017 reset=0 SHALL immediately, without waiting for clk, force IDLE, md_ctrl=00, md_a=0, md_b=0, hi_out=0, lo_out=0, busy=0, done=0, div_zero_exc=0 and counter=0.
REQ-018 Reset in the middle of an operation SHALL abort it with no done or div_zero_exc pulse.
REQ-019 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-020 The macro MULTDIV_SEQUENCER_DIVZERO_EARLY_EN SHALL control early abort of divide-by-zero:
- Defined: in RUN for a div, md_divzero=1 at any edge SHALL force md_ctrl=00 and a move to CAPTURE on that edge, so done and div_zero_exc rise 3 cycles after accept.
- Undefined: the div SHALL run all DIV_CYCLES and the exception SHALL be reported as in REQ-011.

Verification
REQ-021 Mult, rs=0x00010000, rt=0x00030000, responder model -> md_ctrl=01 for exactly 32 cycles; done 34 cycles after accept; hi_out=0x00000003, lo_out=0x00000000.
REQ-022 Div, rs=100, rt=7 -> md_ctrl=10 for exactly 33 cycles; done 35 cycles after accept; lo_out=14, hi_out=2.
REQ-023 Div, rs=5, rt=0, HI/LO preloaded with 0x11111111/0x22222222 -> div_zero_exc and done pulse together; HI/LO unchanged; pulse at cycle 3 with the macro defined, cycle 35 without.
REQ-024 start pulsed at cycle 10 of a mult, then a new start the cycle after done -> first pulse ignored; md_ctrl=00 for at least 2 cycles between operations; second operation completes correctly.
REQ-025 reset=0 mid-clock at cycle 12 of a div -> md_ctrl, busy and hi_out drop to 0 before the next edge; no done; a following mult of 3*4 gives lo_out=12.
REQ-026 mt_hi with rs=0xDEADBEEF while idle -> hi_out=0xDEADBEEF next cycle; mt_lo with start in the same cycle -> lo_out not written by mt.
